count_sweep_ctrl: RTL and testbench

COUNT_SWEEP_CTRL -- requirements
Module: count_sweep_ctrl

---
 rtl/count_sweep_if.sv | 27 ++
 rtl/count_sweep_ctrl.sv | 130 +++++++++++++
 tb/tb_count_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_sweep_if.sv
// Handshake bundle between a sweep sequencer and its up/down counter.
// master drives requests and counter feedback; slave is the sequencer.
interface count_sweep_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [3:0]       sweeps;
  logic [WIDTH-1:0] count;
  logic             cnt_en;
  logic             cnt_dir;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, stop, lo, hi, sweeps, count,
    input  cnt_en, cnt_dir, busy, done, err
  );

  modport slave (
    input  start, stop, lo, hi, sweeps, count,
    output cnt_en, cnt_dir, busy, done, err
  );
endinterface

// File: rtl/count_sweep_ctrl.sv
// Sequences an external up/down counter through lo..hi triangle sweeps.
// Enables are combinational on count so the counter never passes a bound.
module count_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  count_sweep_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    UP,
    DOWN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       sweeps_q, sweeps_d;
  logic [3:0]       rounds_q, rounds_d;
  logic             err_q, err_d;
  logic [3:0]       round_nx;
  logic             active;
  logic             en;
  logic             dir;

  assign round_nx = rounds_q + 4'd1;
  assign active   = (state_q == SEEK) ||
                    (state_q == UP) ||
                    (state_q == DOWN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      sweeps_q <= '0;
      rounds_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      sweeps_q <= sweeps_d;
      rounds_q <= rounds_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    sweeps_d = sweeps_q;
    rounds_d = rounds_q;
    err_d    = 1'b0;
    en       = 1'b0;
    dir      = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.lo < bus.hi) begin
            lo_d     = bus.lo;
            hi_d     = bus.hi;
            sweeps_d = bus.sweeps;
            rounds_d = '0;
            state_d  = SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEEK: begin
        if (bus.count < lo_q) begin
          en = 1'b1;
        end else if (bus.count > lo_q) begin
          en  = 1'b1;
          dir = 1'b0;
        end else begin
          state_d = UP;
        end
      end
      UP: begin
        en = 1'b1;
        if (bus.count >= hi_q) begin
          dir     = 1'b0;
          state_d = DOWN;
        end
      end
      DOWN: begin
        if (bus.count > lo_q) begin
          en  = 1'b1;
          dir = 1'b0;
        end else begin
          rounds_d = round_nx;
          // sweeps==0 runs forever; rounds simply wraps
          if (sweeps_q == 4'd0 || round_nx < sweeps_q) begin
            en      = 1'b1;
            state_d = UP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // stop abandons the sweep at once, leaving the counter where it is
    if (active && bus.stop) begin
      en       = 1'b0;
      dir      = 1'b1;
      state_d  = IDLE;
      rounds_d = rounds_q;
    end
  end

  assign bus.cnt_en  = en;
  assign bus.cnt_dir = dir;
  assign bus.busy    = active;
  assign bus.done    = (state_q == DONE);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Scoreboarded bench for count_sweep_ctrl driving a modelled up/down counter.
// Expected busy-cycle counts and done/err pulses are queued ahead of time.
module tb_count_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  count_sweep_if #(.WIDTH(4)) bus ();

  count_sweep_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] cnt;
  logic       cnt_load;
  logic [3:0] cnt_load_val;

  always @(posedge clk) begin
    if (cnt_load)
      cnt <= cnt_load_val;
    else if (bus.cnt_en)
      cnt <= bus.cnt_dir ? cnt + 4'd1 : cnt - 4'd1;
  end

  assign bus.count = cnt;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int v);
    exp_t e;
    e.kind = 2'(kind);
    e.val  = 4'(v);
    exp_q.push_back(e);
  endtask

  task automatic ramp(input int a, input int b);
    if (a <= b) begin
      for (int i = a; i <= b; i++) push(0, i);
    end else begin
      for (int i = a; i >= b; i--) push(0, i);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] kind;
    exp_t e;
    if (!bus.cnt_en)
      check("dir_idle", 32'(bus.cnt_dir), 32'd1);
    if (bus.busy || bus.done || bus.err) begin
      kind = bus.err ? 2'd2 : (bus.done ? 2'd1 : 2'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: kind %0d count %0d, required none",
                 kind, cnt);
      end else begin
        e = exp_q.pop_front();
        check("out_kind", 32'(kind), 32'(e.kind));
        check("out_count", 32'(cnt), 32'(e.val));
      end
    end
  end

  task automatic do_start(input int l, input int h, input int s);
    @(posedge clk); #1;
    bus.lo     = 4'(l);
    bus.hi     = 4'(h);
    bus.sweeps = 4'(s);
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: %0d items left, required 0",
               name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_left(input int n);
    for (int i = 0; i < 400 && exp_q.size() > n; i++) begin
      @(posedge clk); #1;
    end
    check("wait_left", 32'(exp_q.size()), 32'(n));
  endtask

  task automatic load(input int v);
    @(posedge clk); #1;
    cnt_load     = 1'b1;
    cnt_load_val = 4'(v);
    @(posedge clk); #1;
    cnt_load     = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.lo       = '0;
    bus.hi       = '0;
    bus.sweeps   = '0;
    cnt_load     = 1'b1;
    cnt_load_val = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_en", 32'(bus.cnt_en), 32'd0);
    check("rst_dir", 32'(bus.cnt_dir), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst      = 1'b0;
    cnt_load = 1'b0;

    // single sweep 2..5 from 0
    ramp(0, 2); ramp(2, 5); ramp(4, 2); push(1, 2);
    do_start(2, 5, 1);
    drain("sweep1");
    check("sweep1_busy", 32'(bus.busy), 32'd0);
    check("sweep1_hold", 32'(cnt), 32'd2);

    // rejected starts
    push(2, 2);
    do_start(5, 5, 1);
    drain("err_eq");
    check("err_eq_en", 32'(bus.cnt_en), 32'd0);
    push(2, 2);
    do_start(7, 3, 0);
    drain("err_gt");
    check("err_gt_busy", 32'(bus.busy), 32'd0);

    // stop wins over start in IDLE
    @(posedge clk); #1;
    bus.lo = 4'd1; bus.hi = 4'd3; bus.sweeps = 4'd1;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ss_busy", 32'(bus.busy), 32'd0);

    // continuous 1..3, five triangles then stop
    ramp(2, 1); ramp(1, 3); ramp(2, 1);
    for (int t = 0; t < 4; t++) begin
      ramp(2, 3); ramp(2, 1);
    end
    push(0, 2);
    do_start(1, 3, 0);
    wait_left(1);
    bus.stop = 1'b1;
    @(negedge clk);
    check("stop_en", 32'(bus.cnt_en), 32'd0);
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check("stop_idle", 32'(bus.busy), 32'd0);
    check("stop_cnt", 32'(cnt), 32'd2);
    drain("cont");

    // seek down from 9, two triangles, with mid-sweep noise
    load(9);
    ramp(9, 2); ramp(2, 6); ramp(5, 2); ramp(3, 6); ramp(5, 2);
    push(1, 2);
    do_start(2, 6, 2);
    repeat (3) @(posedge clk);
    #1;
    bus.lo = 4'd0; bus.hi = 4'd9; bus.sweeps = 4'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain("seek2");
    check("seek2_cnt", 32'(cnt), 32'd2);

    // reset during UP at count 4, then a clean sweep
    push(0, 2); ramp(2, 3);
    do_start(2, 5, 1);
    wait_left(0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_en", 32'(bus.cnt_en), 32'd0);
    check("mid_rst_dir", 32'(bus.cnt_dir), 32'd1);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_cnt", 32'(cnt), 32'd4);
    ramp(4, 2); ramp(2, 5); ramp(4, 2); push(1, 2);
    do_start(2, 5, 1);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

endmodule
